lsu_ram_ctrl: RTL and testbench



---
 rtl/lsu_ram_ctrl.sv | 178 +++++++++++++++++
 tb/tb_lsu_ram_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ram_ctrl.sv
// Load/store front-end for the word-wide genram: byte/half/word loads and stores,
// read-modify-write for sub-word stores, sign/zero extension for sub-word loads.
//
// state | meaning
// IDLE  | ready for a request
// RD    | present word address to genram with ram_rw=1
// CAP   | ram_rdata valid; extract load lane or merge store lane
// WR    | drive write word with ram_rw=0
// DONE  | one-cycle response pulse
module lsu_ram_ctrl #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW+1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rw,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          accept;
    logic          req_err;
    logic [4:0]    shamt;
    logic [DW-1:0] lane;
    logic [DW-1:0] lane_mask;
    logic [DW-1:0] load_val;
    logic [DW-1:0] merge_val;

    assign accept = req_valid && (state_q == S_IDLE);

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    // Lane offset in bits, taken from the captured byte address.
    assign shamt = {addr_q[1:0], 3'b000};
    assign lane  = ram_rdata >> shamt;

    always_comb begin
        load_val  = lane;
        lane_mask = 32'hFFFF_FFFF;
        if (size_q == SZ_BYTE) begin
            load_val  = uns_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            lane_mask = 32'h0000_00FF << shamt;
        end else if (size_q == SZ_HALF) begin
            load_val  = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            lane_mask = 32'h0000_FFFF << shamt;
        end
        merge_val = (ram_rdata & ~lane_mask) | ((data_q << shamt) & lane_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = S_DONE;
                    else if (req_we && (req_size == SZ_WORD))
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:    state_d = S_CAP;
            S_CAP:   state_d = we_q ? S_WR : S_DONE;
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    data_d  = req_wdata;
                    rdata_d = '0;
                    err_d   = req_err;
                end
            end
            S_CAP: begin
                if (we_q)
                    data_d = merge_val;
                else
                    rdata_d = load_val;
            end
            S_DONE: begin
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    // Reset forces state_q to IDLE asynchronously, so ram_rw rises immediately.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_DONE);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        ram_addr  = addr_q[AW+1:2];
        ram_rw    = (state_q != S_WR);
        ram_wdata = data_q;
    end

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Directed bench for lsu_ram_ctrl with a behavioural genram model attached.
module tb_lsu_ram_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW+1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] ram_addr;
    logic          ram_rw;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_tests;
    int n_fail;

    lsu_ram_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_addr     (ram_addr),
        .ram_rw       (ram_rw),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // genram: one-cycle read latency, write on the edge closing a ram_rw=0 cycle.
    always @(posedge clk) begin
        if (!ram_rw)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [AW+1:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    // One request: checks latency, response, write activity and req_ready while busy.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [AW+1:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_wcyc, input logic [31:0] exp_waddr,
                           input logic [31:0] exp_wdata);
        int n;
        int wcnt;
        int wcyc;
        int busy_ready;
        logic [31:0] waddr;
        logic [31:0] wdat;
        wcnt = 0; wcyc = 0; busy_ready = 0; waddr = '0; wdat = '0;
        chk({tag, "_ready_idle"}, {31'h0, req_ready}, 32'd1);
        drive(we, size, uns, addr, wdata);
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_size     = 2'b11;
        req_unsigned = ~uns;
        req_addr     = ~addr;
        req_wdata    = 32'h0BAD_0BAD;
        n = 1;
        while (!rsp_valid && n < 10) begin
            if (!ram_rw) begin
                wcnt++; wcyc = n; waddr = {28'h0, ram_addr}; wdat = ram_wdata;
            end
            if (req_ready) busy_ready++;
            @(posedge clk); #1;
            n++;
        end
        if (req_ready) busy_ready++;
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
        chk({tag, "_ready_busy"}, busy_ready, 0);
        chk({tag, "_wr_count"}, wcnt, (exp_wcyc != 0) ? 1 : 0);
        if (exp_wcyc != 0) begin
            chk({tag, "_wr_cycle"}, wcyc, exp_wcyc);
            chk({tag, "_wr_addr"}, waddr, exp_waddr);
            chk({tag, "_wr_data"}, wdat, exp_wdata);
        end
        @(posedge clk); #1;
        chk({tag, "_rsp_drop"}, {31'h0, rsp_valid}, 32'd0);
    endtask

    task automatic set_b2b(input int i);
        case (i % 3)
            0:       drive(1'b0, 2'b10, 1'b0, 6'h04, 32'h0);
            1:       drive(1'b0, 2'b00, 1'b1, 6'h06, 32'h0);
            default: drive(1'b0, 2'b00, 1'b0, 6'h06, 32'h0);
        endcase
    endtask

    function automatic logic [31:0] b2b_exp(input int i);
        case (i % 3)
            0:       return 32'h11AD_1234;
            1:       return 32'h0000_00AD;
            default: return 32'hFFFF_FFAD;
        endcase
    endfunction

    logic [31:0] expq[$];

    initial begin
        int n_acc;
        int n_rsp;
        int overlap;
        int extra;
        int pulses;
        logic acc;
        logic [31:0] exp8;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        ram_rdata    = '0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
        chk("rst_ram_rw", {31'h0, ram_rw}, 32'd1);
        chk("rst_ram_addr", {28'h0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_req("sw", 1'b1, 2'b10, 1'b0, 6'h04, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1, 32'd1, 32'hDEAD_BEEF);
        run_req("lb_s", 1'b0, 2'b00, 1'b0, 6'h05, 32'h0, 3, 32'hFFFF_FFBE, 1'b0, 0, 32'd0, 32'd0);
        run_req("lbu", 1'b0, 2'b00, 1'b1, 6'h05, 32'h0, 3, 32'h0000_00BE, 1'b0, 0, 32'd0, 32'd0);
        run_req("lh_s", 1'b0, 2'b01, 1'b0, 6'h06, 32'h0, 3, 32'hFFFF_DEAD, 1'b0, 0, 32'd0, 32'd0);
        run_req("lw", 1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 0, 32'd0, 32'd0);

        run_req("sb", 1'b1, 2'b00, 1'b0, 6'h07, 32'hAABB_CC11, 4, 32'h0, 1'b0, 3, 32'd1, 32'h11AD_BEEF);
        run_req("lw_sb", 1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 3, 32'h11AD_BEEF, 1'b0, 0, 32'd0, 32'd0);
        run_req("sh", 1'b1, 2'b01, 1'b0, 6'h04, 32'h5566_1234, 4, 32'h0, 1'b0, 3, 32'd1, 32'h11AD_1234);
        run_req("lw_sh", 1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 3, 32'h11AD_1234, 1'b0, 0, 32'd0, 32'd0);
        run_req("lh_hi", 1'b0, 2'b01, 1'b0, 6'h06, 32'h0, 3, 32'h0000_11AD, 1'b0, 0, 32'd0, 32'd0);
        run_req("lb_b3", 1'b0, 2'b00, 1'b0, 6'h07, 32'h0, 3, 32'h0000_0011, 1'b0, 0, 32'd0, 32'd0);

        run_req("sb_top", 1'b1, 2'b00, 1'b0, 6'h3E, 32'h0000_0080, 4, 32'h0, 1'b0, 3, 32'd15, 32'h0080_0000);
        run_req("lb_top", 1'b0, 2'b00, 1'b0, 6'h3E, 32'h0, 3, 32'hFFFF_FF80, 1'b0, 0, 32'd0, 32'd0);

        run_req("err_lh", 1'b0, 2'b01, 1'b0, 6'h05, 32'h0, 1, 32'h0, 1'b1, 0, 32'd0, 32'd0);
        run_req("err_lw", 1'b0, 2'b10, 1'b0, 6'h06, 32'h0, 1, 32'h0, 1'b1, 0, 32'd0, 32'd0);
        run_req("err_sz", 1'b0, 2'b11, 1'b0, 6'h00, 32'h0, 1, 32'h0, 1'b1, 0, 32'd0, 32'd0);
        run_req("err_sw", 1'b1, 2'b10, 1'b0, 6'h09, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, 0, 32'd0, 32'd0);
        run_req("lw_after_err", 1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 3, 32'h11AD_1234, 1'b0, 0, 32'd0, 32'd0);

        // Back-to-back with req_valid held high.
        n_acc = 0; n_rsp = 0; overlap = 0; extra = 0;
        set_b2b(0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n_rsp++;
                if (req_ready) overlap++;
                if (expq.size() == 0) extra++;
                else chk("b2b_rdata", rsp_rdata, expq.pop_front());
            end
            acc = req_valid && req_ready;
            if (acc) expq.push_back(b2b_exp(n_acc));
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                if (n_acc == 6) req_valid = 1'b0;
                else set_b2b(n_acc);
            end
        end
        chk("b2b_accepts", n_acc, 6);
        chk("b2b_responses", n_rsp, 6);
        chk("b2b_ready_in_done", overlap, 0);
        chk("b2b_extra_rsp", extra, 0);

        // Reset while in WR.
        drive(1'b1, 2'b10, 1'b0, 6'h08, 32'hCAFE_F00D);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_wr_in_wr", {31'h0, ram_rw}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wr_ram_rw", {31'h0, ram_rw}, 32'd1);
        chk("rst_wr_ram_addr", {28'h0, ram_addr}, 32'd0);
        chk("rst_wr_ram_wdata", ram_wdata, 32'd0);
        chk("rst_wr_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_wr_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_wr_rsp_err", {31'h0, rsp_err}, 32'd0);
        pulses = 0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) pulses++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) pulses++;
        end
        chk("rst_wr_no_rsp", pulses, 0);
        exp8 = mem[2];
        run_req("lw_post_rst", 1'b0, 2'b10, 1'b0, 6'h08, 32'h0, 3, exp8, 1'b0, 0, 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
